// File: rtl/risc_pkg.sv
// Shared opcode, ALU-op and control-bundle definitions for the 16-bit RISC core.
package risc_pkg;

  localparam logic [3:0] OP_LD      = 4'h0;
  localparam logic [3:0] OP_ST      = 4'h1;
  localparam logic [3:0] OP_R_FIRST = 4'h2;
  localparam logic [3:0] OP_R_LAST  = 4'h9;
  localparam logic [3:0] OP_BEQ     = 4'hB;
  localparam logic [3:0] OP_BNE     = 4'hC;
  localparam logic [3:0] OP_JMP     = 4'hD;

  localparam logic [1:0] ALUOP_ADDR = 2'b10;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b00;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       jump;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode-to-control decode; unknown opcodes yield a NOP flagged illegal.
module control_decode
  import risc_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_LD: begin
        ctrl.alu_op     = ALUOP_ADDR;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_ST: begin
        ctrl.alu_op    = ALUOP_ADDR;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
        ctrl.alu_op    = ALUOP_FUNC;
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op    = ALUOP_BR;
        ctrl.branch_eq = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op    = ALUOP_BR;
        ctrl.branch_ne = 1'b1;
      end
      OP_JMP: begin
        ctrl.alu_op = ALUOP_FUNC;
        ctrl.jump   = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one-deep skid-free bundle register between fetch and execute,
// with flush, sticky illegal-opcode status and a count of bundles handed to execute.
module decode_stage
  import risc_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  input  logic               clr_status,
  output logic [3:0]         out_opcode,
  output logic [1:0]         out_alu_op,
  output logic               out_reg_dst,
  output logic               out_alu_src,
  output logic               out_mem_to_reg,
  output logic               out_reg_write,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic               out_branch_eq,
  output logic               out_branch_ne,
  output logic               out_jump,
  output logic [2:0]         out_rs,
  output logic [2:0]         out_rt,
  output logic [2:0]         out_rd,
  output logic [15:0]        out_imm,
  output logic [11:0]        out_joff,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_illegal,
  output logic               illegal_sticky,
  output logic [CNT_W-1:0]   decoded_count
);

  // Handshake: a side transfers on a cycle where its valid and ready are both 1.
  // in_ready is combinational so a draining bundle can be replaced in the same
  // cycle; flush forces in_ready so fetch's word is consumed and dropped.
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  in_xfer;
  logic  out_xfer;

  control_decode u_control_decode (
    .opcode (in_instr[15:12]),
    .ctrl   (ctrl_d)
  );

  assign in_ready = flush | ~out_valid | out_ready;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      ctrl_q         <= CTRL_NOP;
      out_opcode     <= '0;
      out_rs         <= '0;
      out_rt         <= '0;
      out_rd         <= '0;
      out_imm        <= '0;
      out_joff       <= '0;
      out_pc         <= '0;
      illegal_sticky <= 1'b0;
      decoded_count  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_xfer) begin
        out_valid  <= 1'b1;
        ctrl_q     <= ctrl_d;
        out_opcode <= in_instr[15:12];
        out_rs     <= in_instr[11:9];
        out_rt     <= in_instr[8:6];
        out_rd     <= in_instr[5:3];
        out_imm    <= {{10{in_instr[5]}}, in_instr[5:0]};
        out_joff   <= in_instr[11:0];
        out_pc     <= in_pc;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end

      // A new illegal capture outranks a same-cycle clear.
      if (in_xfer && !flush && ctrl_d.illegal) begin
        illegal_sticky <= 1'b1;
      end else if (clr_status) begin
        illegal_sticky <= 1'b0;
      end

      if (out_xfer && !flush) begin
        decoded_count <= decoded_count + 1'b1;
      end
    end
  end

  assign out_alu_op     = ctrl_q.alu_op;
  assign out_reg_dst    = ctrl_q.reg_dst;
  assign out_alu_src    = ctrl_q.alu_src;
  assign out_mem_to_reg = ctrl_q.mem_to_reg;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_mem_read   = ctrl_q.mem_read;
  assign out_mem_write  = ctrl_q.mem_write;
  assign out_branch_eq  = ctrl_q.branch_eq;
  assign out_branch_ne  = ctrl_q.branch_ne;
  assign out_jump       = ctrl_q.jump;
  assign out_illegal    = ctrl_q.illegal;

endmodule
